// File: rtl/rv_ctrl_pkg.sv
// Shared RV32IM control encodings: opcodes, ALU/MU op codes and EX result-select codes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RALU   = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] MUL_MUL    = 2'd0;
  localparam logic [1:0] MUL_MULH   = 2'd1;
  localparam logic [1:0] MUL_MULHSU = 2'd2;
  localparam logic [1:0] MUL_MULHU  = 2'd3;

  localparam int RES_ALU = 0;
  localparam int RES_MU  = 1;

  // Base integer op selected by func3; func7[5] turns the shift-right slot into SRA.
  function automatic logic [3:0] alu_from_func3(input logic [2:0] f3, input logic sra);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_decode_comb.sv
// Pure combinational EX decode: opcode/func3/func7 bits to ALU, MU and result-select controls.
module ex_decode_comb
  import rv_ctrl_pkg::*;
#(
  parameter int RES_W = 1
) (
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       func3_i,
  input  logic [1:0]       func7b50_i,
  output logic [3:0]       aluctl_o,
  output logic [1:0]       mulctl_o,
  output logic [RES_W-1:0] ifuresctl_o,
  output logic             valid_o
);

  logic [3:0]       alu;
  logic [1:0]       mul;
  logic [RES_W-1:0] res;
  logic             legal;

  always_comb begin
    alu   = ALU_ADD;
    mul   = MUL_MUL;
    res   = RES_W'(RES_ALU);
    legal = 1'b0;
    case (opcode_i)
      OP_RALU: begin
        case (func7b50_i)
          2'b00: begin
            legal = 1'b1;
            alu   = alu_from_func3(func3_i, 1'b0);
          end
          2'b10: begin
            legal = (func3_i == 3'b000) || (func3_i == 3'b101);
            alu   = (func3_i == 3'b101) ? ALU_SRA : ALU_SUB;
          end
          2'b01: begin
            legal = ~func3_i[2];
            mul   = func3_i[1:0];
            res   = RES_W'(RES_MU);
          end
          default: legal = 1'b0;
        endcase
      end
      // func7 bits are immediate bits here; only the shifts interpret func7[5].
      OP_IALU: begin
        legal = !((func3_i == 3'b001) && func7b50_i[1]);
        alu   = alu_from_func3(func3_i, func7b50_i[1]);
      end
      OP_LOAD:  legal = (func3_i != 3'b011) && (func3_i[2:1] != 2'b11);
      OP_STORE: legal = (func3_i[2] == 1'b0) && (func3_i[1:0] != 2'b11);
      OP_AUIPC: legal = 1'b1;
      OP_JAL:   legal = 1'b1;
      OP_JALR:  legal = (func3_i == 3'b000);
      OP_LUI: begin
        legal = 1'b1;
        alu   = ALU_PASSB;
      end
      OP_BRANCH: begin
        legal = (func3_i[2:1] != 2'b01);
        case (func3_i[2:1])
          2'b00:   alu = ALU_SUB;
          2'b10:   alu = ALU_SLT;
          default: alu = ALU_SLTU;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings collapse to a fixed benign control word so the datapath stays quiet.
  assign valid_o     = legal;
  assign aluctl_o    = legal ? alu : ALU_ADD;
  assign mulctl_o    = legal ? mul : MUL_MUL;
  assign ifuresctl_o = legal ? res : RES_W'(RES_ALU);

endmodule

// File: rtl/ex_stage_decoder.sv
// RV32IM execute-stage decoder: registers decoded controls one cycle after the instruction bits.
module ex_stage_decoder
  import rv_ctrl_pkg::*;
#(
  parameter int ifuresctl_N = 2,
  localparam int RES_W = (ifuresctl_N > 1) ? $clog2(ifuresctl_N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [1:0]       func7b50,
  output logic [3:0]       aluctl,
  output logic [1:0]       mulctl,
  output logic [RES_W-1:0] ifuresctl,
  output logic             valid
);

  logic [3:0]       aluctl_d,    aluctl_q;
  logic [1:0]       mulctl_d,    mulctl_q;
  logic [RES_W-1:0] ifuresctl_d, ifuresctl_q;
  logic             valid_d,     valid_q;

  ex_decode_comb #(.RES_W(RES_W)) u_decode (
    .opcode_i    (opcode),
    .func3_i     (func3),
    .func7b50_i  (func7b50),
    .aluctl_o    (aluctl_d),
    .mulctl_o    (mulctl_d),
    .ifuresctl_o (ifuresctl_d),
    .valid_o     (valid_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluctl_q    <= ALU_ADD;
      mulctl_q    <= MUL_MUL;
      ifuresctl_q <= RES_W'(RES_ALU);
      valid_q     <= 1'b0;
    end else begin
      aluctl_q    <= aluctl_d;
      mulctl_q    <= mulctl_d;
      ifuresctl_q <= ifuresctl_d;
      valid_q     <= valid_d;
    end
  end

  assign aluctl    = aluctl_q;
  assign mulctl    = mulctl_q;
  assign ifuresctl = ifuresctl_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_ex_stage_decoder.sv
// Bench for ex_stage_decoder: directed steps plus randomized encodings against a rule-level model.
module tb_ex_stage_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [1:0] func7b50;
  logic [3:0] aluctl;
  logic [1:0] mulctl;
  logic [0:0] ifuresctl;
  logic       valid;

  int checks   = 0;
  int failures = 0;

  // Base integer ops in func3 order (slot 5 is the logical right shift).
  int base_op[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  logic [6:0] opc_pool[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0010111,
                               7'b0110111, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0000000};

  ex_stage_decoder #(.ifuresctl_N(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .func3     (func3),
    .func7b50  (func7b50),
    .aluctl    (aluctl),
    .mulctl    (mulctl),
    .ifuresctl (ifuresctl),
    .valid     (valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {valid, aluctl, mulctl, ifuresctl}, derived directly from the instruction rules.
  function automatic logic [7:0] ref_model(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [1:0] f7);
    int  a  = 0;
    int  m  = 0;
    int  r  = 0;
    bit  ok = 0;
    int  n  = int'(f3);
    case (op)
      7'b0110011: begin
        if (f7 == 2'b00) begin ok = 1; a = base_op[n]; end
        else if (f7 == 2'b10) begin
          if (n == 0) begin ok = 1; a = 1; end
          if (n == 5) begin ok = 1; a = 7; end
        end else if (f7 == 2'b01) begin
          if (n < 4) begin ok = 1; m = n; r = 1; end
        end
      end
      7'b0010011: begin
        ok = !(n == 1 && f7[1]);
        a  = (n == 5 && f7[1]) ? 7 : base_op[n];
      end
      7'b0000011: ok = (n == 0 || n == 1 || n == 2 || n == 4 || n == 5);
      7'b0100011: ok = (n <= 2);
      7'b0010111: ok = 1;
      7'b1101111: ok = 1;
      7'b1100111: ok = (n == 0);
      7'b0110111: begin ok = 1; a = 10; end
      7'b1100011: begin
        ok = (n != 2 && n != 3);
        a  = (n < 2) ? 1 : (n < 6) ? 3 : 4;
      end
      default: ok = 0;
    endcase
    if (!ok) return 8'h00;
    return {1'b1, 4'(a), 2'(m), 1'(r)};
  endfunction

  // driver tasks
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] f7);
    @(negedge clk);
    opcode   = op;
    func3    = f3;
    func7b50 = f7;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare
  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {valid, aluctl, mulctl, ifuresctl};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed v=%0b alu=%0d mul=%0d res=%0d expected v=%0b alu=%0d mul=%0d res=%0d",
             tag, obs[7], obs[6:3], obs[2:1], obs[0], exp[7], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  function automatic logic [7:0] ok_alu(input int a);
    return {1'b1, 4'(a), 2'b00, 1'b0};
  endfunction

  logic [7:0] exp_q[$];

  initial begin
    rst_n    = 1'b0;
    opcode   = 7'($urandom);
    func3    = 3'($urandom);
    func7b50 = 2'($urandom);

    // reset held for three clocks with arbitrary inputs
    repeat (3) begin
      tick();
      check("reset_hold", 8'h00);
      opcode = 7'b0110011; func3 = 3'b000; func7b50 = 2'b00;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("add_after_reset", ok_alu(0));
    tick();
    check("add_held_stable", ok_alu(0));

    // R/I sweep
    drive(7'b0110011, 3'b000, 2'b10); tick(); check("sub",  ok_alu(1));
    drive(7'b0110011, 3'b101, 2'b10); tick(); check("sra",  ok_alu(7));
    drive(7'b0010011, 3'b101, 2'b10); tick(); check("srai", ok_alu(7));
    drive(7'b0010011, 3'b101, 2'b00); tick(); check("srli", ok_alu(6));
    drive(7'b0010011, 3'b111, 2'b11); tick(); check("andi_11", ok_alu(9));
    drive(7'b0010011, 3'b111, 2'b01); tick(); check("andi_01", ok_alu(9));
    drive(7'b0010011, 3'b000, 2'b11); tick(); check("addi_any", ok_alu(0));
    drive(7'b0010011, 3'b001, 2'b10); tick(); check("slli_bad", 8'h00);

    // M extension
    drive(7'b0110011, 3'b011, 2'b01); tick(); check("mulhu", 8'b1_0000_11_1);
    drive(7'b0110011, 3'b001, 2'b01); tick(); check("mulh",  8'b1_0000_01_1);
    drive(7'b0110011, 3'b100, 2'b01); tick(); check("div_illegal", 8'h00);

    // branch / U / J
    drive(7'b1100011, 3'b111, 2'b00); tick(); check("bgeu", ok_alu(4));
    drive(7'b1100011, 3'b001, 2'b00); tick(); check("bne",  ok_alu(1));
    drive(7'b1100011, 3'b100, 2'b00); tick(); check("blt",  ok_alu(3));
    drive(7'b0110111, 3'b010, 2'b11); tick(); check("lui",  ok_alu(10));
    drive(7'b1101111, 3'b110, 2'b01); tick(); check("jal",  ok_alu(0));
    drive(7'b1100111, 3'b000, 2'b00); tick(); check("jalr", ok_alu(0));
    drive(7'b0000011, 3'b101, 2'b00); tick(); check("lhu",  ok_alu(0));

    // illegal encodings
    drive(7'b1111111, 3'b000, 2'b00); tick(); check("bad_opcode",   8'h00);
    drive(7'b0110011, 3'b001, 2'b10); tick(); check("r_001_10",     8'h00);
    drive(7'b0110011, 3'b000, 2'b11); tick(); check("r_f7_11",      8'h00);
    drive(7'b1100011, 3'b010, 2'b00); tick(); check("branch_010",   8'h00);
    drive(7'b0100011, 3'b011, 2'b00); tick(); check("store_011",    8'h00);
    drive(7'b0000011, 3'b110, 2'b00); tick(); check("load_110",     8'h00);
    drive(7'b1100111, 3'b001, 2'b00); tick(); check("jalr_001",     8'h00);

    // timing: exactly one-edge latency on an input change
    drive(7'b0110011, 3'b000, 2'b00); tick(); check("lat_add", ok_alu(0));
    drive(7'b0110011, 3'b000, 2'b01);
    #1 check("lat_before_edge", ok_alu(0));
    tick(); check("lat_mul_after_edge", 8'b1_0000_00_1);

    // async reset between edges
    #1 rst_n = 1'b0;
    #1 check("async_reset_midcycle", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); check("mul_after_rerelease", 8'b1_0000_00_1);

    // randomized encodings: expected values queued at drive time, popped after the edge
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic [1:0] f7;
      op = (i % 8 == 7) ? 7'($urandom) : opc_pool[$urandom_range(0, 9)];
      f3 = 3'($urandom_range(0, 7));
      f7 = 2'($urandom_range(0, 3));
      drive(op, f3, f7);
      exp_q.push_back(ref_model(op, f3, f7));
      tick();
      check("random", exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
